// File: rtl/approx_err_accum.sv
// approx_err_accum
//
// Measures the error of an approximate multiplier over a run of samples.
// Software starts a run with `start` and a sample count; the block then
// accepts that many (in1, in2, approx_prod) samples over a valid/ready
// handshake. For each sample it computes the exact product and the
// absolute error. It accumulates the mismatch count, the sum of absolute
// errors and the maximum absolute error. The results stay on the outputs
// with `done` high until the next start.
//
// Each sample passes through a two-stage pipeline:
//   stage 1 - exact product, absolute error and mismatch flag
//   stage 2 - the accumulators
// A sample therefore shows up in the results two cycles after its handshake.
//
// Optional feature (macro ERR_SQUARED_EN):
//   When the macro is defined, the block adds output sum_sq_err. It
//   accumulates abs_err*abs_err with the same timing and clear rules as
//   sum_abs_err. The default build leaves the macro undefined, which
//   removes both the port and its logic.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle run request (honoured in IDLE/DONE only)
//   num_samples  in   samples in the run, captured when start is accepted
//   in_valid     in   upstream sample valid
//   in_ready     out  high only while the run is accepting samples
//   in1, in2     in   multiplier operands (unsigned, WIDTH bits)
//   approx_prod  in   approximate product (2*WIDTH bits)
//   busy         out  run in progress (RUN or DRAIN)
//   done         out  results valid (DONE)
//   err_count    out  samples whose approx_prod differed from in1*in2
//   sum_abs_err  out  sum of |in1*in2 - approx_prod|
//   sum_sq_err   out  sum of squared errors (ERR_SQUARED_EN only)
//   max_abs_err  out  largest absolute error seen in the run

module approx_err_accum #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_samples,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in1,
    input  logic [WIDTH-1:0]           in2,
    input  logic [2*WIDTH-1:0]         approx_prod,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           err_count,
    output logic [2*WIDTH+CNT_W-1:0]   sum_abs_err,
`ifdef ERR_SQUARED_EN
    output logic [4*WIDTH+CNT_W-1:0]   sum_sq_err,
`endif
    output logic [2*WIDTH-1:0]         max_abs_err
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + CNT_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             start_accept;
    logic             handshake;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;

    logic [PW-1:0]    exact;
    logic [PW-1:0]    abs_err;
    logic             s1_valid;
    logic             s1_mismatch;
    logic [PW-1:0]    s1_abs_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // accepted counts samples taken before this cycle, so
                // this handshake is the last one when accepted+1 hits target.
                if (in_valid && (accepted + CNT_W'(1) == target)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The last sample sits in stage 1 now. Stage 2 absorbs it
                // on this same edge, so the results are complete in DONE.
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = (num_samples == '0) ? DONE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target   <= '0;
            accepted <= '0;
        end else if (start_accept) begin
            target   <= num_samples;
            accepted <= '0;
        end else if (handshake) begin
            accepted <= accepted + CNT_W'(1);
        end
    end

    // The exact product is widened before the multiply so that no bits
    // of in1*in2 are lost.
    assign exact   = PW'(in1) * PW'(in2);
    assign abs_err = (exact >= approx_prod) ? (exact - approx_prod)
                                            : (approx_prod - exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_mismatch <= 1'b0;
            s1_abs_err  <= '0;
        end else begin
            s1_valid <= handshake;
            if (handshake) begin
                s1_mismatch <= (abs_err != '0);
                s1_abs_err  <= abs_err;
            end
        end
    end

    // A start is only accepted in IDLE/DONE. Stage 1 is already empty
    // in those states, so the clear can never drop a pending sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (start_accept) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (s1_valid) begin
            err_count   <= err_count + CNT_W'(s1_mismatch);
            sum_abs_err <= sum_abs_err + SW'(s1_abs_err);
            if (s1_abs_err > max_abs_err) begin
                max_abs_err <= s1_abs_err;
            end
        end
    end

`ifdef ERR_SQUARED_EN
    logic [2*PW-1:0] s1_sq_err;

    // Both factors are widened so that the square keeps all 2*PW bits.
    assign s1_sq_err = (2*PW)'(s1_abs_err) * (2*PW)'(s1_abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_sq_err <= '0;
        end else if (start_accept) begin
            sum_sq_err <= '0;
        end else if (s1_valid) begin
            sum_sq_err <= sum_sq_err + (2*PW+CNT_W)'(s1_sq_err);
        end
    end
`endif

endmodule

// File: doc/approx_err_accum.md
APPROX_ERR_ACCUM -- requirements
Module: approx_err_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the operand width of the upstream approximate multiplier; the product width is PW = 2*WIDTH.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the sample-count and mismatch-count fields.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: start  in  1  single-cycle request to begin a measurement run.
REQ-007 Port: num_samples  in  CNT_W  sample count for the run, sampled when start is accepted.
REQ-008 Port: in_valid  in  1  upstream sample valid.
REQ-009 Port: in_ready  out  1  block accepts a sample this cycle.
REQ-010 Port: in1, in2  in  WIDTH each  unsigned operands applied to the upstream multiplier.
REQ-011 Port: approx_prod  in  PW  approximate product from the upstream multiplier.
REQ-012 Port: busy  out  1  run in progress.
REQ-013 Port: done  out  1  results valid; held high until the next start.
REQ-014 Port: err_count  out  CNT_W  number of samples with approx_prod != in1*in2.
REQ-015 Port: sum_abs_err  out  PW+CNT_W  sum of |in1*in2 - approx_prod|.
REQ-016 Port: max_abs_err  out  PW  largest |in1*in2 - approx_prod| seen in the run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 Transitions: IDLE/DONE + start: num_samples==0 -> DONE, accumulators cleared; otherwise -> RUN, accumulators and the accept counter cleared.
REQ-019 Transitions: RUN -> DRAIN on the handshake that accepts the num_samples-th sample.
REQ-020 Transitions: DRAIN -> DONE once the pipeline is empty, i.e. 2 cycles after the last handshake.
REQ-021 in_ready SHALL be 1 only in RUN; a handshake is in_valid && in_ready.
REQ-022 Stage 1 (registered on handshake): exact = in1*in2, full PW bits; abs_err = |exact - approx_prod|; mismatch = (abs_err != 0); plus a stage-valid bit.
REQ-023 Stage 2 (registered when stage-1 valid): err_count += mismatch; sum_abs_err += abs_err; max_abs_err = max(max_abs_err, abs_err).
REQ-024 Result outputs SHALL reflect a sample 2 cycles after its handshake.
REQ-025 Sums SHALL NOT saturate; the widths are sufficient for 2^CNT_W - 1 samples.
REQ-026 Back-to-back handshakes (in_valid held high) SHALL be accepted one per cycle with no bubbles.
REQ-027 start SHALL be ignored in RUN and DRAIN.
REQ-028 in_valid outside RUN SHALL be ignored and SHALL NOT modify any state.
REQ-029 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE.
REQ-030 Results SHALL hold stable in DONE until the next accepted start.

Reset
REQ-031 On rst_n low, asynchronously: state = IDLE; in_ready, busy, done = 0; err_count, sum_abs_err, max_abs_err = 0; pipeline valid bits = 0.
REQ-032 Reset mid-run SHALL abandon the run; no partial result is flagged done.
REQ-033 The first start after rst_n deasserts SHALL be honoured on the first clock edge.

Configuration
REQ-034 Macro ERR_SQUARED_EN: when defined, the block SHALL add output sum_sq_err (2*PW+CNT_W bits), which accumulates abs_err*abs_err.
REQ-035 With ERR_SQUARED_EN defined, sum_sq_err SHALL use the same stage-2 timing and the same clear and reset rules as sum_abs_err.
REQ-036 Without ERR_SQUARED_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Exact run: start, num_samples=3; samples (63,63,3969), (5,7,35), (0,9,0) -> done; err_count=0, sum_abs_err=0, max_abs_err=0.
REQ-038 Error run: num_samples=2; samples (63,63,3968), (12,10,112) -> err_count=2, sum_abs_err=9, max_abs_err=8; with ERR_SQUARED_EN, sum_sq_err=65.
REQ-039 Zero-count run: num_samples=0 -> done on the cycle after start; in_ready never 1; all results 0.
REQ-040 Back-pressure: num_samples=4, in_valid toggling 1,0,1,1,0,1 -> exactly 4 handshakes; in_ready low after the 4th; done 2 cycles after the 4th handshake.
REQ-041 Robustness: rst_n pulsed low during RUN after 1 of 5 samples -> state IDLE, outputs 0, done stays 0; start during RUN -> no effect on the count.
